pong_match_ctrl: RTL and testbench
==================================

Name: pong_match_ctrl

Overview:
- Match-sequencing FSM for the two-player paddle game.
- Drives the ball datapath through four phases: recentre/serve, run, point award and post-point hold.
- Issues single-cycle p1vic/p2vic pulses to the scoring block and clears the score at match start.
- Sits between the ball/paddle datapath and the scoring block. Consumes that block's game_over flag to end the match.

Parameters:
SERVE_TICKS, 60, tick count (>=1) the ball sits centred before a serve.
HOLD_TICKS, 90, tick count (>=1) of freeze after a point is awarded.
CNT_W, 8, width of the phase countdown counter; must hold max(SERVE_TICKS, HOLD_TICKS).

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high; all state returns to IDLE
tick  in  1  one-cycle frame enable; all phase timing counts ticks
start  in  1  debounced start button level; edge-detected internally
pause  in  1  level; freezes countdowns and ball motion
ball_out_left  in  1  ball crossed left goal line (P1 side)
ball_out_right  in  1  ball crossed right goal line (P2 side)
paddle_hit  in  1  one-cycle pulse per paddle contact
game_over  in  1  from scoring block
ball_reset  out  1  hold ball at centre
ball_run  out  1  ball motion enable
serve_dir  out  1  0 = serve toward left/P1, 1 = toward right/P2
p1vic  out  1  one-cycle point pulse for P1
p2vic  out  1  one-cycle point pulse for P2
score_clr  out  1  one-cycle pulse; OR-ed into the scoring block's reset
winner  out  2  00 none, 01 P1, 10 P2 (last point winner)
rally_len  out  8  paddle hits in the current rally, saturating at 255
speed_level  out  2  min(rally_len>>2, 3)
state  out  3  IDLE=0, SERVE=1, RALLY=2, POINT=3, HOLD=4, OVER=5

Behaviour:
- Reset values:
  - state=IDLE, cnt=0, serve_dir=0, winner=00, rally_len=0.
  - p1vic=0, p2vic=0, score_clr=0, start_r=0.
  - Derived outputs: ball_reset=1, ball_run=0, speed_level=0.
- Start edge: start_pulse = start & ~start_r. start_r updates every cycle in every state.
- Moore outputs, decoded directly from state with no extra latency:
  - ball_reset=1 in every state except RALLY.
  - ball_run = (state==RALLY) & ~pause.
  - p1vic/p2vic are high only in POINT, selected by winner.
- IDLE and OVER:
  - start_pulse -> SERVE; cnt=SERVE_TICKS; serve_dir=0; winner=00; rally_len=0.
  - score_clr registered high for exactly the first SERVE cycle.
  - Any other start activity is ignored.
- SERVE:
  - On tick & ~pause: if cnt==1 -> RALLY, else cnt-1.
  - tick while paused is ignored.
- RALLY, resolved in priority order:
  - out_left & out_right -> SERVE; cnt=SERVE_TICKS; rally_len=0; serve_dir unchanged; no point awarded.
  - out_left only -> POINT; winner=10.
  - out_right only -> POINT; winner=01.
  - Otherwise, paddle_hit increments rally_len, saturating at 255.
  - Goal lines are checked even while paused.
- POINT (exactly 1 cycle):
  - Pulse the winner's vic.
  - serve_dir set toward the loser: winner P1 -> 1, P2 -> 0.
  - -> HOLD; cnt=HOLD_TICKS.
- HOLD:
  - Countdown uses the same rule as SERVE.
  - At completion: game_over=1 -> OVER; else -> SERVE with cnt=SERVE_TICKS and rally_len=0.
  - game_over is sampled only at completion. The scoring block updates it on the edge entering HOLD, so it is valid by then.
- OVER: winner holds the match winner; ball stays frozen.
- Consecutive vic pulses are separated by at least 2 cycles (HOLD+SERVE), satisfying the scoring block's edge detection.
- paddle_hit outside RALLY is ignored.
- game_over outside HOLD is ignored.
- Reset asserted in any state: next cycle is IDLE with reset values; any pending pulse is dropped.

Test Plan:
1. Reset, start rising edge, SERVE_TICKS=3, tick every 4 cycles -> score_clr high 1 cycle; RALLY entered on 3rd tick; ball_reset falls and ball_run rises.
2. In RALLY assert ball_out_right 1 cycle -> POINT 1 cycle with p1vic=1, winner=01, serve_dir=1; then HOLD; then SERVE after HOLD_TICKS ticks; rally_len back to 0.
3. 13 paddle_hit pulses in a rally -> rally_len=13, speed_level=3; 300 hits -> rally_len stays at 255.
4. ball_out_left and ball_out_right together in RALLY -> no vic pulse; SERVE with serve_dir unchanged.
5. pause high during SERVE for 10 ticks -> cnt frozen and ball_run=0; release -> countdown resumes from the same value.
6. game_over=1 at HOLD end -> OVER; start held level produces no restart; new rising edge -> SERVE and score_clr pulse; reset mid-RALLY -> IDLE next cycle.

Source files
------------

// File: rtl/pong_match_ctrl_if.sv
// Signal bundle between the match controller and the ball/paddle datapath and scoring block.
// The controller sits on the slave side. The surrounding game logic, or a bench, drives from the master side.
interface pong_match_ctrl_if;
  logic       tick;
  logic       start;
  logic       pause;
  logic       ball_out_left;
  logic       ball_out_right;
  logic       paddle_hit;
  logic       game_over;
  logic       ball_reset;
  logic       ball_run;
  logic       serve_dir;
  logic       p1vic;
  logic       p2vic;
  logic       score_clr;
  logic [1:0] winner;
  logic [7:0] rally_len;
  logic [1:0] speed_level;
  logic [2:0] state;

  modport slave (
    input  tick, start, pause, ball_out_left, ball_out_right, paddle_hit, game_over,
    output ball_reset, ball_run, serve_dir, p1vic, p2vic, score_clr,
           winner, rally_len, speed_level, state
  );

  modport master (
    output tick, start, pause, ball_out_left, ball_out_right, paddle_hit, game_over,
    input  ball_reset, ball_run, serve_dir, p1vic, p2vic, score_clr,
           winner, rally_len, speed_level, state
  );
endinterface

// File: rtl/pong_match_ctrl.sv
// Match-sequencing FSM for the two-player paddle game. It runs each point through
// serve, rally, point award and hold, and issues the vic and score-clear pulses.
module pong_match_ctrl #(
  parameter int unsigned SERVE_TICKS = 60,
  parameter int unsigned HOLD_TICKS  = 90,
  parameter int unsigned CNT_W       = 8
) (
  input logic             clock,
  input logic             reset,
  pong_match_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    RALLY = 3'd2,
    POINT = 3'd3,
    HOLD  = 3'd4,
    OVER  = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] SERVE_LOAD = CNT_W'(SERVE_TICKS);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_TICKS);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           cur, nxt;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             dir_q, dir_n;
  logic [1:0]       win_q, win_n;
  logic [7:0]       rl_q, rl_n;
  logic             clr_q, clr_n;
  logic             start_r;

  logic start_pulse;
  logic count_en;
  logic count_last;

  assign start_pulse = bus.start & ~start_r;
  assign count_en    = bus.tick & ~bus.pause;
  assign count_last  = count_en && (cnt == CNT_ONE);

  always_ff @(posedge clock) begin
    if (reset) begin
      cur     <= IDLE;
      cnt     <= '0;
      dir_q   <= 1'b0;
      win_q   <= 2'b00;
      rl_q    <= '0;
      clr_q   <= 1'b0;
      start_r <= 1'b0;
    end else begin
      cur     <= nxt;
      cnt     <= cnt_n;
      dir_q   <= dir_n;
      win_q   <= win_n;
      rl_q    <= rl_n;
      clr_q   <= clr_n;
      start_r <= bus.start;
    end
  end

  always_comb begin
    nxt   = cur;
    cnt_n = cnt;
    dir_n = dir_q;
    win_n = win_q;
    rl_n  = rl_q;
    clr_n = 1'b0;
    unique case (cur)
      IDLE, OVER: begin
        if (start_pulse) begin
          nxt   = SERVE;
          cnt_n = SERVE_LOAD;
          dir_n = 1'b0;
          win_n = 2'b00;
          rl_n  = '0;
          clr_n = 1'b1;
        end
      end
      SERVE: begin
        if (count_last)    nxt   = RALLY;
        else if (count_en) cnt_n = cnt - CNT_ONE;
      end
      RALLY: begin
        // Goal lines are decided even while paused. Serve direction is set on
        // entry to POINT so that it already points at the loser during the pulse cycle.
        if (bus.ball_out_left && bus.ball_out_right) begin
          nxt   = SERVE;
          cnt_n = SERVE_LOAD;
          rl_n  = '0;
        end else if (bus.ball_out_left) begin
          nxt   = POINT;
          win_n = 2'b10;
          dir_n = 1'b0;
        end else if (bus.ball_out_right) begin
          nxt   = POINT;
          win_n = 2'b01;
          dir_n = 1'b1;
        end else if (bus.paddle_hit && (rl_q != 8'hFF)) begin
          rl_n = rl_q + 8'd1;
        end
      end
      POINT: begin
        nxt   = HOLD;
        cnt_n = HOLD_LOAD;
      end
      HOLD: begin
        if (count_last) begin
          if (bus.game_over) begin
            nxt = OVER;
          end else begin
            nxt   = SERVE;
            cnt_n = SERVE_LOAD;
            rl_n  = '0;
          end
        end else if (count_en) begin
          cnt_n = cnt - CNT_ONE;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  assign bus.state       = cur;
  assign bus.ball_reset  = (cur != RALLY);
  assign bus.ball_run    = (cur == RALLY) & ~bus.pause;
  assign bus.p1vic       = (cur == POINT) && (win_q == 2'b01);
  assign bus.p2vic       = (cur == POINT) && (win_q == 2'b10);
  assign bus.score_clr   = clr_q;
  assign bus.serve_dir   = dir_q;
  assign bus.winner      = win_q;
  assign bus.rally_len   = rl_q;
  assign bus.speed_level = (rl_q[7:4] != 4'd0) ? 2'd3 : rl_q[3:2];

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Scoreboard bench for pong_match_ctrl. The stimulus queues the expected state at each transition,
// and a negedge monitor pops and compares whenever the state output changes.
module tb_pong_match_ctrl;
  localparam int unsigned SERVE_T = 3;
  localparam int unsigned HOLD_T  = 4;

  localparam logic [2:0] S_IDLE = 3'd0, S_SERVE = 3'd1, S_RALLY = 3'd2,
                         S_POINT = 3'd3, S_HOLD = 3'd4, S_OVER = 3'd5;

  logic clock = 1'b0;
  logic reset = 1'b1;

  pong_match_ctrl_if bus();

  pong_match_ctrl #(.SERVE_TICKS(SERVE_T), .HOLD_TICKS(HOLD_T), .CNT_W(8)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0] st;
    logic [1:0] win;
    logic       dir;
    logic [7:0] rl;
    logic       p1;
    logic       p2;
    logic       clr;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  logic [2:0] prev_st;
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic push(input logic [2:0] st, input logic [1:0] win, input logic dir,
                      input logic [7:0] rl, input logic p1, input logic p2, input logic clr);
    exp_t x;
    x.st = st; x.win = win; x.dir = dir; x.rl = rl; x.p1 = p1; x.p2 = p2; x.clr = clr;
    exp_q.push_back(x);
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_tick();
    bus.tick = 1'b1;
    cyc();
    bus.tick = 1'b0;
    cyc(); cyc(); cyc();
  endtask

  task automatic hit();
    bus.paddle_hit = 1'b1;
    cyc();
    bus.paddle_hit = 1'b0;
    cyc();
  endtask

  task automatic goal(input logic left, input logic right);
    bus.ball_out_left  = left;
    bus.ball_out_right = right;
    cyc();
    bus.ball_out_left  = 1'b0;
    bus.ball_out_right = 1'b0;
    cyc();
  endtask

  // Monitor: every state change consumes one queued expectation.
  initial begin
    prev_st = S_IDLE;
    forever begin
      @(negedge clock);
      if (reset) begin
        prev_st = S_IDLE;
      end else if (bus.state !== prev_st) begin
        prev_st = bus.state;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_transition: got state %0d, expected no transition", bus.state);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("st%0d_state", e.st), 32'(bus.state), 32'(e.st));
          check($sformatf("st%0d_winner", e.st), 32'(bus.winner), 32'(e.win));
          check($sformatf("st%0d_serve_dir", e.st), 32'(bus.serve_dir), 32'(e.dir));
          check($sformatf("st%0d_rally_len", e.st), 32'(bus.rally_len), 32'(e.rl));
          check($sformatf("st%0d_p1vic", e.st), 32'(bus.p1vic), 32'(e.p1));
          check($sformatf("st%0d_p2vic", e.st), 32'(bus.p2vic), 32'(e.p2));
          check($sformatf("st%0d_score_clr", e.st), 32'(bus.score_clr), 32'(e.clr));
          check($sformatf("st%0d_ball_reset", e.st), 32'(bus.ball_reset), 32'(e.st != S_RALLY));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no end of stimulus, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    bus.tick = 1'b0; bus.start = 1'b0; bus.pause = 1'b0;
    bus.ball_out_left = 1'b0; bus.ball_out_right = 1'b0;
    bus.paddle_hit = 1'b0; bus.game_over = 1'b0;
    reset = 1'b1;
    repeat (3) cyc();

    check("rst_state",      32'(bus.state), 32'(S_IDLE));
    check("rst_ball_reset", 32'(bus.ball_reset), 32'd1);
    check("rst_ball_run",   32'(bus.ball_run), 32'd0);
    check("rst_vic",        32'({bus.p1vic, bus.p2vic}), 32'd0);
    check("rst_score_clr",  32'(bus.score_clr), 32'd0);
    check("rst_winner",     32'(bus.winner), 32'd0);
    check("rst_rally_len",  32'(bus.rally_len), 32'd0);
    check("rst_speed",      32'(bus.speed_level), 32'd0);
    check("rst_serve_dir",  32'(bus.serve_dir), 32'd0);
    reset = 1'b0;
    cyc();

    // Start the match. score_clr is high in the first SERVE cycle, and the third tick leads to RALLY.
    push(S_SERVE, 2'b00, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    bus.start = 1'b1;
    cyc();
    check("serve_clr_first", 32'(bus.score_clr), 32'd1);
    pulse_tick();
    check("serve_clr_once", 32'(bus.score_clr), 32'd0);
    pulse_tick();
    check("serve_after_2_ticks", 32'(bus.state), 32'(S_SERVE));
    push(S_RALLY, 2'b00, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    pulse_tick();
    check("rally_ball_reset", 32'(bus.ball_reset), 32'd0);
    check("rally_ball_run",   32'(bus.ball_run), 32'd1);

    // Rally length and speed level
    repeat (5) hit();
    check("rl_5",    32'(bus.rally_len), 32'd5);
    check("speed_5", 32'(bus.speed_level), 32'd1);
    repeat (8) hit();
    check("rl_13",    32'(bus.rally_len), 32'd13);
    check("speed_13", 32'(bus.speed_level), 32'd3);

    // A right-side goal gives P1 the point. game_over is high early in HOLD and
    // drops before the last tick, so it must be ignored.
    push(S_POINT, 2'b01, 1'b1, 8'd13, 1'b1, 1'b0, 1'b0);
    push(S_HOLD,  2'b01, 1'b1, 8'd13, 1'b0, 1'b0, 1'b0);
    push(S_SERVE, 2'b01, 1'b1, 8'd0,  1'b0, 1'b0, 1'b0);
    goal(1'b0, 1'b1);
    bus.game_over = 1'b1;
    repeat (3) pulse_tick();
    check("hold_after_3_ticks", 32'(bus.state), 32'(S_HOLD));
    bus.game_over = 1'b0;
    pulse_tick();
    check("serve_after_hold", 32'(bus.state), 32'(S_SERVE));
    check("rl_cleared",       32'(bus.rally_len), 32'd0);

    // Rally length saturates. A double goal re-serves with no point awarded.
    push(S_RALLY, 2'b01, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
    repeat (3) pulse_tick();
    repeat (300) hit();
    check("rl_sat",    32'(bus.rally_len), 32'd255);
    check("speed_sat", 32'(bus.speed_level), 32'd3);
    push(S_SERVE, 2'b01, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
    goal(1'b1, 1'b1);
    check("double_goal_serve", 32'(bus.state), 32'(S_SERVE));
    check("double_goal_dir",   32'(bus.serve_dir), 32'd1);

    // Pausing in SERVE freezes the countdown at 2. Paddle hits outside RALLY are ignored.
    pulse_tick();
    bus.pause = 1'b1;
    hit();
    repeat (10) pulse_tick();
    check("paused_serve",    32'(bus.state), 32'(S_SERVE));
    check("paused_ball_run", 32'(bus.ball_run), 32'd0);
    bus.pause = 1'b0;
    pulse_tick();
    check("resume_one_left", 32'(bus.state), 32'(S_SERVE));
    push(S_RALLY, 2'b01, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
    pulse_tick();
    check("resume_rally",   32'(bus.state), 32'(S_RALLY));
    check("resume_ball_run", 32'(bus.ball_run), 32'd1);
    bus.pause = 1'b1;
    cyc();
    check("rally_paused_run",   32'(bus.ball_run), 32'd0);
    check("rally_paused_reset", 32'(bus.ball_reset), 32'd0);

    // A left goal while paused gives P2 the point. game_over at the end of HOLD leads to OVER.
    push(S_POINT, 2'b10, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    push(S_HOLD,  2'b10, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    push(S_OVER,  2'b10, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    goal(1'b1, 1'b0);
    bus.pause = 1'b0;
    bus.game_over = 1'b1;
    repeat (4) pulse_tick();
    bus.game_over = 1'b0;

    // Holding start high in OVER must not restart the match. A fresh rising edge does.
    repeat (5) cyc();
    check("over_level_start", 32'(bus.state), 32'(S_OVER));
    check("over_winner",      32'(bus.winner), 32'd2);
    bus.start = 1'b0;
    cyc();
    push(S_SERVE, 2'b00, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    bus.start = 1'b1;
    cyc();
    check("restart_clr", 32'(bus.score_clr), 32'd1);
    push(S_RALLY, 2'b00, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    repeat (3) pulse_tick();
    hit(); hit();
    check("rl_before_reset", 32'(bus.rally_len), 32'd2);

    // Asserting reset in the middle of a rally
    reset = 1'b1;
    bus.start = 1'b0;
    cyc();
    check("midrst_state",  32'(bus.state), 32'(S_IDLE));
    check("midrst_rl",     32'(bus.rally_len), 32'd0);
    check("midrst_winner", 32'(bus.winner), 32'd0);
    check("midrst_run",    32'(bus.ball_run), 32'd0);
    check("midrst_reset",  32'(bus.ball_reset), 32'd1);
    reset = 1'b0;
    repeat (2) cyc();
    check("idle_after_reset", 32'(bus.state), 32'(S_IDLE));

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
